// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// State encoding, opcode classes, ALU function codes and control word.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [2:0] CLS_RTYPE = 3'b000;
    localparam logic [2:0] CLS_ALUI  = 3'b001;
    localparam logic [2:0] CLS_LOAD  = 3'b010;
    localparam logic [2:0] CLS_STORE = 3'b011;
    localparam logic [2:0] CLS_CMP   = 3'b100;
    localparam logic [2:0] CLS_HALT  = 3'b101;

    localparam logic [2:0] ALU_IMM   = 3'b100;
    localparam logic [2:0] ALU_LOAD  = 3'b101;
    localparam logic [2:0] ALU_STORE = 3'b110;
    localparam logic [2:0] ALU_CMP   = 3'b111;

    // Per-class control word; the top gates it by state.
    typedef struct packed {
        logic legal;
        logic is_halt;
        logic to_mem;
        logic to_wb;
        logic is_load;
        logic is_store;
        logic alu_src;
        logic reg_dst;
        logic wb_sel_alu;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational class/function decoder for the multi-cycle control unit.
// Maps an opcode/function value to the control word and ALU function.
module multicycle_control_decode
    import multicycle_control_pkg::*;
#(
    parameter int OPFN_W  = 5,
    parameter int ALUFN_W = 3
) (
    input  logic [OPFN_W-1:0]  opfn,
    output ctrl_t              ctrl,
    output logic [ALUFN_W-1:0] alu_fn
);

    logic [2:0]        cls;
    logic [OPFN_W-4:0] fn;

    assign cls = opfn[OPFN_W-1:OPFN_W-3];
    assign fn  = opfn[OPFN_W-4:0];

    // Class lookup; undefined classes leave legal cleared.
    always_comb begin
        ctrl            = '0;
        ctrl.wb_sel_alu = 1'b1;
        alu_fn          = '0;
        case (cls)
            CLS_RTYPE: begin
                ctrl.legal   = 1'b1;
                ctrl.to_wb   = 1'b1;
                ctrl.reg_dst = 1'b1;
                alu_fn       = ALUFN_W'(fn);
            end
            CLS_ALUI: begin
                ctrl.legal   = 1'b1;
                ctrl.to_wb   = 1'b1;
                ctrl.alu_src = 1'b1;
                alu_fn       = ALUFN_W'(ALU_IMM);
            end
            CLS_LOAD: begin
                ctrl.legal      = 1'b1;
                ctrl.to_mem     = 1'b1;
                ctrl.is_load    = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.wb_sel_alu = 1'b0;
                alu_fn          = ALUFN_W'(ALU_LOAD);
            end
            CLS_STORE: begin
                ctrl.legal    = 1'b1;
                ctrl.to_mem   = 1'b1;
                ctrl.is_store = 1'b1;
                ctrl.alu_src  = 1'b1;
                alu_fn        = ALUFN_W'(ALU_STORE);
            end
            CLS_CMP: begin
                ctrl.legal = 1'b1;
                alu_fn     = ALUFN_W'(ALU_CMP);
            end
            CLS_HALT: begin
                ctrl.legal   = 1'b1;
                ctrl.is_halt = 1'b1;
            end
            default: begin
                ctrl.legal      = 1'b0;
                ctrl.wb_sel_alu = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback.
// Define MULTICYCLE_CONTROL_TIMEOUT_EN to build the MEM-state watchdog.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPFN_W      = 5,
    parameter int ALUFN_W     = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OPFN_W-1:0]  opfn,
    input  logic               mem_ready,
    output logic               ifetch,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src,
    output logic [ALUFN_W-1:0] alu_fn,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_sel_alu,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic               mem_timeout
);

    if (ALUFN_W < OPFN_W - 2) begin : g_bad_alufn
        $error("ALUFN_W too narrow for the function field");
    end
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_to
        $error("MEM_TIMEOUT out of range 1..255");
    end

    state_t              state;
    state_t              state_n;
    logic [OPFN_W-1:0]   op_q;
    logic [OPFN_W-1:0]   dec_in;
    ctrl_t               ctrl;
    logic [ALUFN_W-1:0]  dec_fn;
    logic                in_instr;
    logic                expire;

    // DECODE judges the live opcode; later phases see only the capture.
    assign dec_in = (state == DECODE) ? opfn : op_q;

    multicycle_control_decode #(
        .OPFN_W  (OPFN_W),
        .ALUFN_W (ALUFN_W)
    ) u_decode (
        .opfn   (dec_in),
        .ctrl   (ctrl),
        .alu_fn (dec_fn)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Opcode capture, loaded only while in DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
        end else if (state == DECODE) begin
            op_q <= opfn;
        end
    end

`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Count stalled MEM cycles; cleared whenever not in MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != MEM) begin
            wait_cnt <= '0;
        end else if (!mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign expire = (state == MEM) && !mem_ready &&
                    (wait_cnt == 8'(MEM_TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

    // Next state and per-phase enables; mem_ready always beats expiry.
    always_comb begin
        state_n     = state;
        ifetch      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                ifetch = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_n  = DECODE;
                end
            end
            DECODE: begin
                if (!ctrl.legal) begin
                    illegal  = 1'b1;
                    pc_write = 1'b1;
                    state_n  = FETCH;
                end else if (ctrl.is_halt) begin
                    state_n = HALT;
                end else begin
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (ctrl.to_mem) begin
                    state_n = MEM;
                end else if (ctrl.to_wb) begin
                    state_n = WB;
                end else begin
                    pc_write = 1'b1;
                    state_n  = FETCH;
                end
            end
            MEM: begin
                mem_read  = ctrl.is_load;
                mem_write = ctrl.is_store;
                if (mem_ready) begin
                    if (ctrl.is_load) begin
                        state_n = WB;
                    end else begin
                        pc_write = 1'b1;
                        state_n  = FETCH;
                    end
                end else if (expire) begin
                    mem_timeout = 1'b1;
                    state_n     = HALT;
                end
            end
            WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_n   = FETCH;
            end
            HALT: begin
                state_n = HALT;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign in_instr   = (state == EXEC) || (state == MEM) || (state == WB);
    assign alu_fn     = in_instr ? dec_fn : '0;
    assign alu_src    = in_instr & ctrl.alu_src;
    assign reg_dst    = in_instr & ctrl.reg_dst;
    assign wb_sel_alu = in_instr & ctrl.wb_sel_alu;
    assign busy       = (state != IDLE) && (state != HALT);
    assign halted     = (state == HALT);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control.
// Directed instruction vectors; a monitor checks each retired instruction.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] opfn;
    logic       mem_ready;
    logic       ifetch, ir_write, pc_write, reg_dst, reg_write, alu_src;
    logic [2:0] alu_fn;
    logic       mem_read, mem_write, wb_sel_alu, busy, halted;
    logic       illegal, mem_timeout;

    multicycle_control #(
        .OPFN_W      (5),
        .ALUFN_W     (3),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .opfn        (opfn),
        .mem_ready   (mem_ready),
        .ifetch      (ifetch),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src     (alu_src),
        .alu_fn      (alu_fn),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .wb_sel_alu  (wb_sel_alu),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_halt;
        int         cyc;
        logic       rw;
        logic [2:0] alu;
        logic       src;
        logic       rd;
        logic       wb;
        logic       ill;
        int         mrd;
        int         mwr;
        int         to;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle-scripted driver; opfn is garbage outside DECODE.
    task automatic drive(input logic [4:0] op, input int fw, input int mw);
        logic [2:0] c;
        c = op[4:2];
        repeat (fw) begin
            mem_ready = 1'b0;
            opfn      = 5'($urandom);
            step();
        end
        mem_ready = 1'b1;
        opfn      = 5'($urandom);
        step();
        opfn      = op;
        mem_ready = 1'($urandom);
        step();
        opfn = 5'($urandom);
        if (c >= 3'b101) return;
        mem_ready = 1'($urandom);
        step();
        if (c == 3'b010 || c == 3'b011) begin
            repeat (mw) begin
                mem_ready = 1'b0;
                opfn      = 5'($urandom);
                step();
            end
            mem_ready = 1'b1;
            step();
        end
        if (c <= 3'b010) begin
            mem_ready = 1'($urandom);
            step();
        end
    endtask

    task automatic instr(input logic [4:0] op, input int fw, input int mw,
                         input int cyc, input logic rw, input logic [2:0] alu,
                         input logic src, input logic rd, input logic wb,
                         input logic ill, input int mrd, input int mwr);
        exp_t e;
        e.is_halt = 1'b0;
        e.cyc = cyc; e.rw = rw; e.alu = alu; e.src = src; e.rd = rd;
        e.wb = wb; e.ill = ill; e.mrd = mrd; e.mwr = mwr; e.to = 0;
        sbq.push_back(e);
        drive(op, fw, mw);
    endtask

    task automatic push_halt(input int cyc, input int mrd, input int to);
        exp_t e;
        e = '{default: 0};
        e.is_halt = 1'b1;
        e.cyc = cyc; e.mrd = mrd; e.to = to;
        sbq.push_back(e);
    endtask

    int   m_cyc, m_mrd, m_mwr, m_to, m_rw, m_ill;
    logic halted_d;

    // Monitor: accumulate per-instruction activity, check on retire/halt.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            m_cyc = 0; m_mrd = 0; m_mwr = 0; m_to = 0; m_rw = 0; m_ill = 0;
            halted_d = 1'b0;
        end else begin
            if (busy) m_cyc++;
            if (mem_read) m_mrd++;
            if (mem_write) m_mwr++;
            if (mem_timeout) m_to++;
            if (reg_write) m_rw++;
            if (illegal) m_ill++;
            if (pc_write || (halted && !halted_d)) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_retire: got pc_write=%0b halted=%0b expected none",
                             pc_write, halted);
                end else begin
                    e = sbq.pop_front();
                    chk("kind_halt", halted, e.is_halt);
                    chk("latency", m_cyc, e.cyc);
                    chk("mem_read_cycles", m_mrd, e.mrd);
                    chk("mem_timeout_cnt", m_to, e.to);
                    if (e.is_halt) begin
                        chk("halt_busy", busy, 0);
                        chk("halt_ifetch", ifetch, 0);
                    end else begin
                        chk("reg_write", reg_write, e.rw);
                        chk("reg_write_cnt", m_rw, 32'(e.rw));
                        chk("alu_fn", alu_fn, e.alu);
                        chk("alu_src", alu_src, e.src);
                        chk("reg_dst", reg_dst, e.rd);
                        chk("wb_sel_alu", wb_sel_alu, e.wb);
                        chk("illegal", m_ill, 32'(e.ill));
                        chk("mem_write_cycles", m_mwr, e.mwr);
                    end
                end
                m_cyc = 0; m_mrd = 0; m_mwr = 0; m_to = 0; m_rw = 0; m_ill = 0;
            end
            halted_d = halted;
        end
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got no finish expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; opfn = '0;
        step();
        step();
        chk("reset_outputs",
            {ifetch, ir_write, pc_write, reg_dst, reg_write, alu_src, alu_fn,
             mem_read, mem_write, wb_sel_alu, busy, halted, illegal,
             mem_timeout}, 0);
        rst = 1'b0; start = 1'b1;
        step();
        chk("first_fetch", ifetch, 1);

        //    op        fw mw cyc rw alu     src rd wb ill mrd mwr
        instr(5'b00010, 0, 0, 4,  1, 3'b010, 0,  1, 1, 0,  0,  0);
        instr(5'b01000, 0, 3, 8,  1, 3'b101, 1,  0, 0, 0,  4,  0);
        instr(5'b01100, 0, 0, 4,  0, 3'b110, 1,  0, 1, 0,  0,  1);
        instr(5'b00111, 2, 0, 6,  1, 3'b100, 1,  0, 1, 0,  0,  0);
        instr(5'b10001, 1, 0, 4,  0, 3'b111, 0,  0, 1, 0,  0,  0);
        instr(5'b00011, 0, 0, 4,  1, 3'b011, 0,  1, 1, 0,  0,  0);
        instr(5'b01101, 0, 2, 6,  0, 3'b110, 1,  0, 1, 0,  0,  3);
        instr(5'b11000, 0, 0, 2,  0, 3'b000, 0,  0, 0, 1,  0,  0);
        instr(5'b11111, 1, 0, 3,  0, 3'b000, 0,  0, 0, 1,  0,  0);
        instr(5'b00000, 0, 0, 4,  1, 3'b000, 0,  1, 1, 0,  0,  0);

        push_halt(2, 0, 0);
        drive(5'b10100, 0, 0);
        repeat (5) step();
        chk("halt_sticky", {halted, busy, ifetch}, 3'b100);

        // Reset mid-store: enables must clear without a clock edge.
        rst = 1'b1;
        step();
        rst = 1'b0; start = 1'b1;
        step();
        mem_ready = 1'b1;
        step();
        opfn = 5'b01100;
        step();
        opfn = 5'b00000;
        step();
        mem_ready = 1'b0;
        #1;
        chk("store_mem_write", mem_write, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_mem_write", {mem_write, busy}, 0);
        start = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("idle_after_rst", {busy, halted, ifetch}, 0);
        start = 1'b1;
        step();
        chk("refetch", ifetch, 1);

`ifdef MULTICYCLE_CONTROL_TIMEOUT_EN
        instr(5'b01000, 0, 14, 19, 1, 3'b101, 1, 0, 0, 0, 15, 0);
        push_halt(18, 15, 1);
        mem_ready = 1'b1;
        step();
        opfn = 5'b01000;
        step();
        opfn = 5'b11111;
        step();
        mem_ready = 1'b0;
        repeat (14) step();
        chk("timeout_pulse", {mem_timeout, mem_read}, 2'b11);
        step();
        chk("timeout_halt", {halted, mem_read, mem_timeout}, 3'b100);
`else
        instr(5'b01000, 0, 20, 25, 1, 3'b101, 1, 0, 0, 0, 21, 0);
`endif

        step();
        step();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
